// File: rtl/elevator_scheduler_if.sv
// rtl/elevator_scheduler_if.sv - button/interlock inputs and car status outputs of the elevator scheduler
interface elevator_scheduler_if #(
    parameter int FLOORS = 3
);
    logic [FLOORS-1:0] button;
    logic              sos;
    logic              overweight;
    logic [FLOORS-1:0] call_led;
    logic [FLOORS-1:0] floor;
    logic              door;
    logic              moving;
    logic              dir_up;
    logic              sos_mode;
    logic              weight_limit_exceeded;

    modport master (
        output button, sos, overweight,
        input  call_led, floor, door, moving, dir_up, sos_mode, weight_limit_exceeded
    );

    modport slave (
        input  button, sos, overweight,
        output call_led, floor, door, moving, dir_up, sos_mode, weight_limit_exceeded
    );
endinterface

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN elevator sequencer with SOS/overweight interlocks; DOOR_REOPEN_EN extends dwell on a same-floor press
module elevator_scheduler #(
    parameter int FLOORS       = 3,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    elevator_scheduler_if.slave  bus
);
    localparam int CUR_W    = (FLOORS > 1) ? $clog2(FLOORS) : 1;
    localparam int MAX_TICK = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TW       = $clog2(MAX_TICK) + 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CUR_W-1:0]  cur, cur_next;
    logic [TW-1:0]     travel_cnt, travel_next;
    logic [TW-1:0]     door_cnt, door_next;
    logic [FLOORS-1:0] calls, calls_next;
    logic              dir_up_r, dir_next;
    logic              sos_r;
    logic              wle_r, wle_next;

    logic              above, below;
    logic [FLOORS-1:0] cur_mask, press, clear;
    logic [CUR_W-1:0]  step_floor;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur        <= '0;
            travel_cnt <= '0;
            door_cnt   <= '0;
            calls      <= '0;
            dir_up_r   <= 1'b1;
            sos_r      <= 1'b0;
            wle_r      <= 1'b0;
        end else begin
            state      <= state_next;
            cur        <= cur_next;
            travel_cnt <= travel_next;
            door_cnt   <= door_next;
            calls      <= calls_next;
            dir_up_r   <= dir_next;
            sos_r      <= bus.sos;
            wle_r      <= wle_next;
        end
    end

    // Pending calls strictly above / below the current floor drive the SCAN choice.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (calls[i] && (i > int'(cur))) above = 1'b1;
            if (calls[i] && (i < int'(cur))) below = 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        cur_next    = cur;
        travel_next = travel_cnt;
        door_next   = door_cnt;
        dir_next    = dir_up_r;
        clear       = '0;
        cur_mask    = FLOORS'(1) << cur;
        step_floor  = dir_up_r ? (cur + CUR_W'(1)) : (cur - CUR_W'(1));
        press       = bus.button;
        wle_next    = (state == DOOR_OPEN) && bus.overweight;

        // The floor being served never re-latches its own call.
        if (state == DOOR_OPEN) begin
            press = bus.button & ~cur_mask;
        end

        if (!bus.sos) begin
            case (state)
                IDLE: begin
                    if (calls[cur]) begin
                        state_next = DOOR_OPEN;
                        door_next  = '0;
                        clear      = cur_mask;
                    end else if (above && (dir_up_r || !below)) begin
                        state_next  = MOVING;
                        dir_next    = 1'b1;
                        travel_next = '0;
                    end else if (below) begin
                        state_next  = MOVING;
                        dir_next    = 1'b0;
                        travel_next = '0;
                    end
                end
                MOVING: begin
                    if (travel_cnt == TRAVEL_LAST) begin
                        travel_next = '0;
                        cur_next    = step_floor;
                        if (calls[step_floor]) begin
                            state_next = DOOR_OPEN;
                            door_next  = '0;
                            clear      = FLOORS'(1) << step_floor;
                        end
                    end else begin
                        travel_next = travel_cnt + TW'(1);
                    end
                end
                DOOR_OPEN: begin
`ifdef DOOR_REOPEN_EN
                    if (bus.button[cur]) begin
                        door_next = '0;
                    end else
`endif
                    if (bus.overweight) begin
                        door_next = door_cnt;
                    end else if (door_cnt == DOOR_LAST) begin
                        state_next = IDLE;
                        door_next  = '0;
                    end else begin
                        door_next = door_cnt + TW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        calls_next = (calls | press) & ~clear;
    end

    assign bus.call_led              = calls;
    assign bus.floor                 = FLOORS'(1) << cur;
    assign bus.door                  = (state == DOOR_OPEN);
    assign bus.moving                = (state == MOVING) && !sos_r;
    assign bus.dir_up                = dir_up_r;
    assign bus.sos_mode              = sos_r;
    assign bus.weight_limit_exceeded = wle_r;
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - randomized scoreboard bench for elevator_scheduler against a countdown reference model
module tb_elevator_scheduler;
    localparam int F  = 3;
    localparam int TT = 2;
    localparam int DT = 3;

    typedef struct packed {
        logic [F-1:0] call_led;
        logic [F-1:0] floor;
        logic         door;
        logic         moving;
        logic         dir_up;
        logic         sos_mode;
        logic         wle;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elevator_scheduler_if #(.FLOORS(F)) bus ();

    elevator_scheduler #(
        .FLOORS(F), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle_no = 0;

    // Reference model: whole-floor integer position, phases with countdown of remaining ticks.
    localparam int PH_IDLE = 0, PH_MOVE = 1, PH_DOOR = 2;
    int     m_floor;
    int     m_phase;
    int     m_tleft;
    int     m_dleft;
    bit     m_call[F];
    bit     m_up;
    bit     m_sos;
    bit     m_wle;

    function automatic bit calls_above();
        for (int i = m_floor + 1; i < F; i++) if (m_call[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit calls_below();
        for (int i = 0; i < m_floor; i++) if (m_call[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit r, input bit [F-1:0] b, input bit s, input bit o);
        bit latch[F];
        bit served[F];
        int old_phase;
        int old_floor;
        if (!r) begin
            m_floor = 0; m_phase = PH_IDLE; m_tleft = TT; m_dleft = DT;
            for (int i = 0; i < F; i++) m_call[i] = 1'b0;
            m_up = 1'b1; m_sos = 1'b0; m_wle = 1'b0;
            return;
        end
        old_phase = m_phase;
        old_floor = m_floor;
        for (int i = 0; i < F; i++) begin
            latch[i]  = b[i] && !(old_phase == PH_DOOR && i == old_floor);
            served[i] = 1'b0;
        end
        if (!s) begin
            if (m_phase == PH_IDLE) begin
                if (m_call[m_floor]) begin
                    m_phase = PH_DOOR; m_dleft = DT; served[m_floor] = 1'b1;
                end else if (calls_above() && (m_up || !calls_below())) begin
                    m_up = 1'b1; m_phase = PH_MOVE; m_tleft = TT;
                end else if (calls_below()) begin
                    m_up = 1'b0; m_phase = PH_MOVE; m_tleft = TT;
                end
            end else if (m_phase == PH_MOVE) begin
                m_tleft--;
                if (m_tleft == 0) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    m_tleft = TT;
                    if (m_call[m_floor]) begin
                        m_phase = PH_DOOR; m_dleft = DT; served[m_floor] = 1'b1;
                    end
                end
            end else begin
`ifdef DOOR_REOPEN_EN
                if (b[m_floor]) m_dleft = DT;
                else
`endif
                if (!o) begin
                    m_dleft--;
                    if (m_dleft == 0) m_phase = PH_IDLE;
                end
            end
        end
        for (int i = 0; i < F; i++) m_call[i] = (m_call[i] || latch[i]) && !served[i];
        m_wle = (old_phase == PH_DOOR) && o;
        m_sos = s;
    endtask

    function automatic obs_t model_obs();
        obs_t e;
        e = '0;
        for (int i = 0; i < F; i++) e.call_led[i] = m_call[i];
        e.floor[m_floor] = 1'b1;
        e.door     = (m_phase == PH_DOOR);
        e.moving   = (m_phase == PH_MOVE) && !m_sos;
        e.dir_up   = m_up;
        e.sos_mode = m_sos;
        e.wle      = m_wle;
        return e;
    endfunction

    task automatic apply(input bit r, input bit [F-1:0] b, input bit s, input bit o);
        @(negedge clk);
        rst_n          = r;
        bus.button     = b;
        bus.sos        = s;
        bus.overweight = o;
        model_step(r, b, s, o);
        exp_q.push_back(model_obs());
    endtask

    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{call_led: bus.call_led, floor: bus.floor, door: bus.door,
                        moving: bus.moving, dir_up: bus.dir_up, sos_mode: bus.sos_mode,
                        wle: bus.weight_limit_exceeded};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got call=%b floor=%b door=%b mov=%b up=%b sos=%b wle=%b, want call=%b floor=%b door=%b mov=%b up=%b sos=%b wle=%b",
                             cycle_no, got.call_led, got.floor, got.door, got.moving, got.dir_up, got.sos_mode, got.wle,
                             e.call_led, e.floor, e.door, e.moving, e.dir_up, e.sos_mode, e.wle);
                end
            end
        end
    end

    initial begin
        int sos_left;
        int ow_left;
        int rst_left;
        bit [F-1:0] b;
        bus.button = '0;
        bus.sos = 1'b0;
        bus.overweight = 1'b0;

        // Reset, then single far call, then same-floor call, then SCAN reversal.
        repeat (2) apply(1'b0, '0, 1'b0, 1'b0);
        repeat (2) apply(1'b1, '0, 1'b0, 1'b0);
        apply(1'b1, 3'b100, 1'b0, 1'b0);
        repeat (10) apply(1'b1, '0, 1'b0, 1'b0);
        apply(1'b1, 3'b100, 1'b0, 1'b0);
        repeat (8) apply(1'b1, '0, 1'b0, 1'b0);
        apply(1'b1, 3'b001, 1'b0, 1'b0);
        repeat (14) apply(1'b1, '0, 1'b0, 1'b0);
        apply(1'b1, 3'b100, 1'b0, 1'b0);
        repeat (3) apply(1'b1, '0, 1'b0, 1'b0);
        apply(1'b1, 3'b001, 1'b0, 1'b0);
        repeat (16) apply(1'b1, '0, 1'b0, 1'b0);
        // SOS mid-travel, then overweight during the dwell.
        apply(1'b1, 3'b010, 1'b0, 1'b0);
        repeat (2) apply(1'b1, '0, 1'b0, 1'b0);
        repeat (5) apply(1'b1, '0, 1'b1, 1'b0);
        repeat (3) apply(1'b1, '0, 1'b0, 1'b0);
        repeat (4) apply(1'b1, '0, 1'b0, 1'b1);
        repeat (8) apply(1'b1, '0, 1'b0, 1'b0);

        sos_left = 0; ow_left = 0; rst_left = 0;
        for (int n = 0; n < 3000; n++) begin
            b = '0;
            if ($urandom_range(5) == 0) b[$urandom_range(F - 1)] = 1'b1;
            if (sos_left == 0 && $urandom_range(39) == 0) sos_left = $urandom_range(6, 1);
            if (ow_left == 0 && $urandom_range(14) == 0) ow_left = $urandom_range(5, 1);
            if (rst_left == 0 && $urandom_range(599) == 0) rst_left = $urandom_range(2, 1);
            apply(rst_left == 0, b, sos_left != 0, ow_left != 0);
            if (sos_left > 0) sos_left--;
            if (ow_left > 0) ow_left--;
            if (rst_left > 0) rst_left--;
        end

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
